// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL bring-up / domain reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_seq_state_e;

  localparam int LOST_CNT_W = 8;

  // One shared phase counter must hold the longest interval any state times.
  function automatic int seq_cnt_width(input int a, input int b, input int c,
                                       input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock indication into the refclk domain.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  // Shift the asynchronous lock through two refclk stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and per-domain reset sequencer, refclk domain only.
// Optional lock-timeout retry/fail behaviour enabled by PLL_SEQ_RETRY_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CLOCKS          = 5,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  i_refclk,
  input  logic                  i_rst,
  input  logic                  i_pll_locked,
  output logic                  o_pll_rst,
  output logic [NUM_CLOCKS-1:0] o_domain_rst,
  output logic                  o_ready,
  output logic                  o_fail,
  output logic [LOST_CNT_W-1:0] o_lock_lost_count
);

  // Release span is included so the last domain offset is always representable.
  localparam int CNT_W = seq_cnt_width(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES,
                                       NUM_CLOCKS * RELEASE_GAP_CYCLES, MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_CLOCKS - 1) * RELEASE_GAP_CYCLES);
`ifdef PLL_SEQ_RETRY_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX    = CNT_W'(MAX_RETRIES);
`endif

  logic                  w_locked_sync;
  pll_seq_state_e        r_state;
  pll_seq_state_e        w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_lock_drop;
  logic [LOST_CNT_W-1:0] r_lost;
  logic [LOST_CNT_W-1:0] w_lost_nxt;
  logic [NUM_CLOCKS-1:0] w_domain_nxt;
  logic                  r_pll_rst;
  logic [NUM_CLOCKS-1:0] r_domain_rst;
  logic                  r_ready;
`ifdef PLL_SEQ_RETRY_EN
  logic [CNT_W-1:0]      r_retry;
  logic [CNT_W-1:0]      w_retry_nxt;
  logic                  r_fail;
`endif

  pll_lock_sync u_lock_sync (
    .i_clk   (i_refclk),
    .i_rst   (i_rst),
    .i_async (i_pll_locked),
    .o_sync  (w_locked_sync)
  );

  // Next-state and counter logic; the counter defaults to 0 so every state entry starts fresh.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = {CNT_W{1'b0}};
    w_lock_drop = 1'b0;
`ifdef PLL_SEQ_RETRY_EN
    w_retry_nxt = r_retry;
`endif
    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == PULSE_LAST) w_state_nxt = ST_WAIT_LOCK;
        else                     w_cnt_nxt   = r_cnt + CNT_ONE;
      end
      ST_WAIT_LOCK: begin
        if (w_locked_sync) w_state_nxt = ST_STABLE;
`ifdef PLL_SEQ_RETRY_EN
        else if (r_cnt != TIMEOUT_LAST) w_cnt_nxt = r_cnt + CNT_ONE;
        else if (r_retry < RETRY_MAX) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = r_retry + CNT_ONE;
        end else begin
          w_state_nxt = ST_FAIL;
        end
`else
        else w_cnt_nxt = {CNT_W{1'b0}};
`endif
      end
      ST_STABLE: begin
        if (!w_locked_sync)            w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = ST_RELEASE;
        else                           w_cnt_nxt   = r_cnt + CNT_ONE;
      end
      ST_RELEASE: begin
        if (!w_locked_sync)             w_lock_drop = 1'b1;
        else if (r_cnt == RELEASE_LAST) w_state_nxt = ST_RUN;
        else                            w_cnt_nxt   = r_cnt + CNT_ONE;
      end
      ST_RUN: begin
        if (!w_locked_sync) w_lock_drop = 1'b1;
        else                w_state_nxt = ST_RUN;
      end
      ST_FAIL: w_state_nxt = ST_FAIL;
      default: w_state_nxt = ST_RESET_PLL;
    endcase

    if (w_lock_drop) begin
      w_state_nxt = ST_RESET_PLL;
      w_lost_nxt  = (r_lost == {LOST_CNT_W{1'b1}}) ? r_lost : r_lost + LOST_CNT_W'(1);
`ifdef PLL_SEQ_RETRY_EN
      w_retry_nxt = {CNT_W{1'b0}};
`endif
    end else begin
      w_lost_nxt = r_lost;
    end
  end

  // Domain k is released once the release phase has run k gaps, and stays released in RUN.
  always_comb begin
    for (int k = 0; k < NUM_CLOCKS; k++) begin
      w_domain_nxt[k] = ~((w_state_nxt == ST_RUN) ||
                          ((w_state_nxt == ST_RELEASE) &&
                           (w_cnt_nxt >= CNT_W'(k * RELEASE_GAP_CYCLES))));
    end
  end

  // State, counters and outputs registered together so outputs track the current state.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state      <= ST_RESET_PLL;
      r_cnt        <= {CNT_W{1'b0}};
      r_lost       <= {LOST_CNT_W{1'b0}};
      r_pll_rst    <= 1'b1;
      r_domain_rst <= {NUM_CLOCKS{1'b1}};
      r_ready      <= 1'b0;
`ifdef PLL_SEQ_RETRY_EN
      r_retry      <= {CNT_W{1'b0}};
      r_fail       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lost       <= w_lost_nxt;
      r_pll_rst    <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
      r_domain_rst <= w_domain_nxt;
      r_ready      <= (w_state_nxt == ST_RUN);
`ifdef PLL_SEQ_RETRY_EN
      r_retry      <= w_retry_nxt;
      r_fail       <= (w_state_nxt == ST_FAIL);
`endif
    end
  end

  assign o_pll_rst         = r_pll_rst;
  assign o_domain_rst      = r_domain_rst;
  assign o_ready           = r_ready;
  assign o_lock_lost_count = r_lost;
`ifdef PLL_SEQ_RETRY_EN
  assign o_fail            = r_fail;
`else
  assign o_fail            = 1'b0;
`endif

endmodule
